// File: rtl/down_counter_163.sv
// Synchronous cascadable down-counter with 74163-style controls, borrow ripple,
// optional auto-reload, a registered terminal-count pulse and a sticky underflow flag.
module down_counter_163 #(
    parameter int              WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_l,
    input  logic             ld_l,
    input  logic [WIDTH-1:0] d,
    input  logic             enp,
    input  logic             ent,
    input  logic             reload_en,
    input  logic [WIDTH-1:0] reload_val,
    input  logic             sticky_clr,
    output logic [WIDTH-1:0] q,
    output logic             rco,
    output logic             tc_pulse,
    output logic             uf_sticky
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             r_uf;

    logic             w_zero;
    logic             w_count;
    logic             w_uf_event;
    logic [WIDTH-1:0] w_q_next_count;

    assign w_zero     = (r_q == '0);
    assign w_count    = clr_l & ld_l & enp & ent;
    assign w_uf_event = w_count & w_zero;

    // Underflow either reloads the programmed modulus or wraps to all-ones.
    assign w_q_next_count = w_zero ? (reload_en ? reload_val : {WIDTH{1'b1}})
                                   : (r_q - ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q  <= RST_VAL;
            r_tc <= 1'b0;
            r_uf <= 1'b0;
        end else begin
            if (!clr_l) begin
                r_q  <= '0;
                r_tc <= 1'b0;
            end else if (!ld_l) begin
                r_q  <= d;
                r_tc <= 1'b0;
            end else if (w_count) begin
                r_q  <= w_q_next_count;
                r_tc <= w_zero;
            end else begin
                r_tc <= 1'b0;
            end

            // A new underflow outranks a simultaneous clear request.
            if (w_uf_event) begin
                r_uf <= 1'b1;
            end else if (sticky_clr) begin
                r_uf <= 1'b0;
            end
        end
    end

    assign q         = r_q;
    assign rco       = ent & w_zero;
    assign tc_pulse  = r_tc;
    assign uf_sticky = r_uf;

endmodule

// File: tb/tb_down_counter_163.sv
// Directed bench for down_counter_163: vector table for a single stage plus a
// hand-written two-stage cascade sequence.
module tb_down_counter_163;

    logic       clk = 1'b0;
    logic       rst, clr_l, ld_l, enp, ent, reload_en, sticky_clr;
    logic [3:0] d, reload_val;
    logic [3:0] q;
    logic       rco, tc_pulse, uf_sticky;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    down_counter_163 #(.WIDTH(4), .RST_VAL(4'h0)) dut (
        .clk(clk), .rst(rst), .clr_l(clr_l), .ld_l(ld_l), .d(d),
        .enp(enp), .ent(ent), .reload_en(reload_en), .reload_val(reload_val),
        .sticky_clr(sticky_clr), .q(q), .rco(rco), .tc_pulse(tc_pulse),
        .uf_sticky(uf_sticky)
    );

    // Cascade: low stage rco drives high stage ent.
    logic       c_rst, c_ld_l, c_enp, c_ent, c_sclr;
    logic [3:0] c_dlo, c_dhi, c_qlo, c_qhi;
    logic       c_rco_lo, c_rco_hi, c_tc_lo, c_tc_hi, c_uf_lo, c_uf_hi;

    down_counter_163 #(.WIDTH(4), .RST_VAL(4'h0)) u_lo (
        .clk(clk), .rst(c_rst), .clr_l(1'b1), .ld_l(c_ld_l), .d(c_dlo),
        .enp(c_enp), .ent(c_ent), .reload_en(1'b0), .reload_val(4'h0),
        .sticky_clr(c_sclr), .q(c_qlo), .rco(c_rco_lo), .tc_pulse(c_tc_lo),
        .uf_sticky(c_uf_lo)
    );

    down_counter_163 #(.WIDTH(4), .RST_VAL(4'h0)) u_hi (
        .clk(clk), .rst(c_rst), .clr_l(1'b1), .ld_l(c_ld_l), .d(c_dhi),
        .enp(c_enp), .ent(c_rco_lo), .reload_en(1'b0), .reload_val(4'h0),
        .sticky_clr(c_sclr), .q(c_qhi), .rco(c_rco_hi), .tc_pulse(c_tc_hi),
        .uf_sticky(c_uf_hi)
    );

    typedef struct {
        logic       rst, clr_l, ld_l, enp, ent, reload_en, sticky_clr;
        logic [3:0] d, reload_val;
        logic [3:0] exp_q;
        logic       exp_tc, exp_uf, exp_rco;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic cl, input logic ld, input logic [3:0] dd,
                       input logic p, input logic t, input logic re, input logic [3:0] rv,
                       input logic sc, input logic [3:0] eq, input logic etc,
                       input logic euf, input logic erco);
        vec_t v;
        v.rst = r; v.clr_l = cl; v.ld_l = ld; v.d = dd; v.enp = p; v.ent = t;
        v.reload_en = re; v.reload_val = rv; v.sticky_clr = sc;
        v.exp_q = eq; v.exp_tc = etc; v.exp_uf = euf; v.exp_rco = erco;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        //   rst cl ld d   p t re rv  sc  q    tc uf rco
        // Reset
        add(1, 1, 1, 4'h0, 1, 1, 0, 4'h0, 0, 4'h0, 0, 0, 1);
        // Load 3 then count 3,2,1,0,F,E with wrap
        add(0, 1, 0, 4'h3, 1, 1, 0, 4'h0, 0, 4'h3, 0, 0, 0);
        add(0, 1, 1, 4'h0, 1, 1, 0, 4'h0, 0, 4'h2, 0, 0, 0);
        add(0, 1, 1, 4'h0, 1, 1, 0, 4'h0, 0, 4'h1, 0, 0, 0);
        add(0, 1, 1, 4'h0, 1, 1, 0, 4'h0, 0, 4'h0, 0, 0, 1);
        add(0, 1, 1, 4'h0, 1, 1, 0, 4'h0, 0, 4'hF, 1, 1, 0);
        add(0, 1, 1, 4'h0, 1, 1, 0, 4'h0, 0, 4'hE, 0, 1, 0);
        // Load 0, then modulo-5 reload for 15 edges: 4,3,2,1,0 repeating
        add(0, 1, 0, 4'h0, 1, 1, 1, 4'h4, 0, 4'h0, 0, 1, 1);
        for (int k = 0; k < 15; k++) begin
            logic [3:0] eq;
            eq = 4'(4 - (k % 5));
            add(0, 1, 1, 4'h0, 1, 1, 1, 4'h4, 0, eq, (k % 5) == 0, 1, eq == 4'h0);
        end
        // q=0: ent low holds and drops rco; enp low with ent high holds, rco=1, sticky cleared
        add(0, 1, 1, 4'h0, 1, 0, 1, 4'h4, 0, 4'h0, 0, 1, 0);
        add(0, 1, 1, 4'h0, 0, 1, 1, 4'h4, 1, 4'h0, 0, 0, 1);
        // Wrap from 0 sets sticky again; reload back to 0
        add(0, 1, 1, 4'h0, 1, 1, 0, 4'h0, 0, 4'hF, 1, 1, 0);
        add(0, 1, 0, 4'h0, 1, 1, 0, 4'h0, 0, 4'h0, 0, 1, 1);
        // Clear and load together at q=0 with enables high: clear wins, no underflow
        add(0, 0, 0, 4'h9, 1, 1, 0, 4'h0, 0, 4'h0, 0, 1, 1);
        add(0, 1, 0, 4'h9, 1, 1, 0, 4'h0, 0, 4'h9, 0, 1, 0);
        // Clear from nonzero
        add(0, 0, 1, 4'h0, 1, 1, 0, 4'h0, 0, 4'h0, 0, 1, 1);
        // Divide-by-1: reload 0 keeps q at 0, tc every enabled cycle
        add(0, 1, 1, 4'h0, 1, 1, 1, 4'h0, 0, 4'h0, 1, 1, 1);
        add(0, 1, 1, 4'h0, 1, 1, 1, 4'h0, 1, 4'h0, 1, 1, 1);
        // Hold with sticky_clr drops tc and sticky
        add(0, 1, 1, 4'h0, 0, 1, 1, 4'h0, 1, 4'h0, 0, 0, 1);
        // Load, then reset mid-count overrides everything
        add(0, 1, 0, 4'h7, 1, 1, 0, 4'h0, 0, 4'h7, 0, 0, 0);
        add(0, 1, 1, 4'h0, 1, 1, 0, 4'h0, 0, 4'h6, 0, 0, 0);
        add(1, 0, 0, 4'h5, 1, 1, 1, 4'h3, 1, 4'h0, 0, 0, 1);

        c_rst = 1'b1; c_ld_l = 1'b1; c_enp = 1'b0; c_ent = 1'b0; c_sclr = 1'b0;
        c_dlo = 4'h0; c_dhi = 4'h0;

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; clr_l = vecs[i].clr_l; ld_l = vecs[i].ld_l;
            d = vecs[i].d; enp = vecs[i].enp; ent = vecs[i].ent;
            reload_en = vecs[i].reload_en; reload_val = vecs[i].reload_val;
            sticky_clr = vecs[i].sticky_clr;
            @(posedge clk);
            #1;
            check("q", i, {4'h0, q}, {4'h0, vecs[i].exp_q});
            check("tc_pulse", i, {7'h0, tc_pulse}, {7'h0, vecs[i].exp_tc});
            check("uf_sticky", i, {7'h0, uf_sticky}, {7'h0, vecs[i].exp_uf});
            check("rco", i, {7'h0, rco}, {7'h0, vecs[i].exp_rco});
        end

        // rco follows ent within the same cycle, no edge involved
        @(negedge clk);
        rst = 1'b0; clr_l = 1'b1; ld_l = 1'b1; enp = 1'b0; ent = 1'b1;
        #1 check("rco_ent_hi", 0, {7'h0, rco}, 8'h1);
        ent = 1'b0;
        #1 check("rco_ent_lo", 0, {7'h0, rco}, 8'h0);

        // Cascade sequence
        @(negedge clk);
        @(posedge clk); #1;
        check("casc_rst", 0, {c_qhi, c_qlo}, 8'h00);
        @(negedge clk);
        c_rst = 1'b0; c_ld_l = 1'b0; c_dhi = 4'h0; c_dlo = 4'h1;
        @(posedge clk); #1;
        check("casc_load", 1, {c_qhi, c_qlo}, 8'h01);
        @(negedge clk);
        c_ld_l = 1'b1; c_enp = 1'b1; c_ent = 1'b1;
        @(posedge clk); #1;
        check("casc_e1", 2, {c_qhi, c_qlo}, 8'h00);
        check("casc_rco_lo", 2, {7'h0, c_rco_lo}, 8'h1);
        check("casc_tc_e1", 2, {6'h0, c_tc_hi, c_tc_lo}, 8'h0);
        @(negedge clk);
        c_sclr = 1'b1;
        @(posedge clk); #1;
        check("casc_e2", 3, {c_qhi, c_qlo}, 8'hFF);
        check("casc_tc_e2", 3, {6'h0, c_tc_hi, c_tc_lo}, 8'h3);
        check("casc_uf_e2", 3, {6'h0, c_uf_hi, c_uf_lo}, 8'h3);
        @(posedge clk); #1;
        check("casc_e3", 4, {c_qhi, c_qlo}, 8'hFE);
        check("casc_tc_e3", 4, {6'h0, c_tc_hi, c_tc_lo}, 8'h0);
        check("casc_uf_e3", 4, {6'h0, c_uf_hi, c_uf_lo}, 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
